// File: rtl/keypad_scan_ctrl_pkg.sv
// keypad_pkg: shared scan states, column constants and key-code decoding for the 4x4 keypad.
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_e;
    localparam logic [3:0] COL0 = 4'b1000;
    localparam logic [3:0] COL1 = 4'b0100;
    localparam logic [3:0] COL2 = 4'b0010;
    localparam logic [3:0] COL3 = 4'b0001;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    function automatic logic [3:0] onehot_idx(input logic [3:0] v);
        return v[3] ? 4'd0 : v[2] ? 4'd1 : v[1] ? 4'd2 : 4'd3;
    endfunction

    function automatic logic single_row(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Digits 1..9 fill the upper-left 3x3, letters run down the last row, col3 holds * 0 #.
    function automatic logic [3:0] key_decode(input logic [3:0] col, input logic [3:0] row);
        logic [3:0] c;
        logic [3:0] r;
        c = onehot_idx(col);
        r = onehot_idx(row);
        return r == 4'd3 ? (c == 4'd3 ? 4'hD : 4'hA + c) :
               c == 4'd3 ? (r == 4'd0 ? KEY_STAR : r == 4'd1 ? 4'h0 : KEY_HASH) :
               4'(c * 4'd3 + r + 4'd1);
    endfunction
endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: key-event handshake and status toward the digit-entry logic.
interface keypad_scan_ctrl_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_down;
    logic       overrun;
    logic       ovr_clr;

    modport master (output key_code, key_valid, key_down, overrun, input key_ready, ovr_clr);
    modport slave  (input key_code, key_valid, key_down, overrun, output key_ready, ovr_clr);
endinterface

// File: rtl/keypad_scan_ctrl_scan_tick_gen.sv
// scan_tick_gen: prescaler producing a one-cycle tick every SCAN_DIV clocks.
module scan_tick_gen #(
    parameter int SCAN_DIV = 450000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = $clog2(SCAN_DIV);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == W'(SCAN_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scan FSM with press/release debouncing and a one-deep key event register.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 450000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas,
    output logic [3:0] col,
    keypad_scan_ctrl_if.master kif
);
    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

    logic       tick;
    state_e     state_q, state_d;
    logic [3:0] col_q, col_d, row_q, row_d;
    logic [3:0] deb_q, deb_d, rel_q, rel_d;
    logic [3:0] code_q, code_d;
    logic       down_q, down_d, valid_q, valid_d, ovr_q, ovr_d;
    logic       ev, load, drop;
    logic [3:0] deb_inc, rel_inc, col_next;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        deb_d    = deb_q;
        rel_d    = rel_q;
        down_d   = down_q;
        ev       = 1'b0;
        deb_inc  = deb_q + 4'd1;
        rel_inc  = rel_q + 4'd1;
        col_next = {col_q[0], col_q[3:1]};
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (single_row(filas)) begin
                        row_d = filas;
                        deb_d = 4'd1;
                        if (DS == 4'd1) begin
                            ev      = 1'b1;
                            down_d  = 1'b1;
                            rel_d   = 4'd0;
                            state_d = PRESSED;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (filas == row_q) begin
                        deb_d = deb_inc;
                        if (deb_inc == DS) begin
                            ev      = 1'b1;
                            down_d  = 1'b1;
                            rel_d   = 4'd0;
                            state_d = PRESSED;
                        end
                    end else begin
                        deb_d   = 4'd0;
                        col_d   = col_next;
                        state_d = SCAN;
                    end
                end
                PRESSED: begin
                    // Any row activity while held restarts the release count; no auto-repeat.
                    rel_d = filas == 4'd0 ? rel_inc : 4'd0;
                    if (filas == 4'd0 && rel_inc == DS) begin
                        down_d  = 1'b0;
                        deb_d   = 4'd0;
                        col_d   = col_next;
                        state_d = SCAN;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
        load    = ev && (!valid_q || kif.key_ready);
        drop    = ev && valid_q && !kif.key_ready;
        code_d  = load ? key_decode(col_q, filas) : code_q;
        valid_d = load || (valid_q && !kif.key_ready);
        ovr_d   = drop || (ovr_q && !kif.ovr_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            col_q   <= COL0;
            row_q   <= 4'd0;
            deb_q   <= 4'd0;
            rel_q   <= 4'd0;
            code_q  <= 4'd0;
            down_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            deb_q   <= deb_d;
            rel_q   <= rel_d;
            code_q  <= code_d;
            down_q  <= down_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign col           = col_q;
    assign kif.key_code  = code_q;
    assign kif.key_valid = valid_q;
    assign kif.key_down  = down_q;
    assign kif.overrun   = ovr_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: key-map table, directed corner sequences and random stimulus against a scan model.
module tb_keypad_scan_ctrl;
    localparam int SD = 4;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] filas = 4'd0;
    logic [3:0] col;
    int         total = 0;
    int         bad = 0;
    int         xfers = 0;
    logic [3:0] last_code = 4'd0;

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst_n(rst_n), .filas(filas), .col(col), .kif(kif)
    );

    always #5 clk = ~clk;

    // Reference: a key is reported once it is seen DS ticks in a row on one column;
    // scanning stays parked on that column until the keypad reads empty DS ticks in a row.
    logic [3:0] mcode [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    int         m_div, m_ci, m_mode, m_n;
    logic [3:0] m_row, m_code;
    logic       m_valid, m_down, m_ovr;

    task automatic model_reset();
        m_div = 0; m_ci = 0; m_mode = 0; m_n = 0; m_row = 4'd0;
        m_code = 4'd0; m_valid = 1'b0; m_down = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] f, input logic rdy, input logic clr);
        bit tk, ev, drop;
        int ri;
        tk = m_div == SD - 1;
        m_div = tk ? 0 : m_div + 1;
        ev = 0;
        drop = 0;
        if (tk) begin
            if (m_mode == 0) begin
                if ($countones(f) == 1) begin
                    m_row = f; m_n = 1; m_mode = 1;
                end else m_ci = (m_ci + 1) % 4;
            end else if (m_mode == 1) begin
                if (f == m_row) m_n++;
                else begin m_mode = 0; m_ci = (m_ci + 1) % 4; end
            end else begin
                m_n = f == 4'd0 ? m_n + 1 : 0;
                if (m_n == DS) begin m_down = 0; m_mode = 0; m_ci = (m_ci + 1) % 4; end
            end
            if (m_mode == 1 && m_n == DS) begin
                ev = 1; m_mode = 2; m_n = 0; m_down = 1;
            end
        end
        ri = 0;
        for (int b = 0; b < 4; b++) if (m_row[3-b]) ri = b;
        if (ev && m_valid && !rdy) drop = 1;
        else if (ev) begin m_valid = 1; m_code = mcode[m_ci*4+ri]; end
        else if (m_valid && rdy) m_valid = 0;
        m_ovr = drop ? 1'b1 : (clr ? 1'b0 : m_ovr);
    endtask

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
        end
    endtask

    task automatic cyc();
        if (kif.key_valid && kif.key_ready) begin xfers++; last_code = kif.key_code; end
        @(posedge clk);
        model_step(filas, kif.key_ready, kif.ovr_clr);
        @(negedge clk);
        chk("m_col", {4'd0, col}, {4'd0, 4'b1000 >> m_ci});
        chk("m_valid", {7'd0, kif.key_valid}, {7'd0, m_valid});
        chk("m_code", {4'd0, kif.key_code}, {4'd0, m_code});
        chk("m_down", {7'd0, kif.key_down}, {7'd0, m_down});
        chk("m_ovr", {7'd0, kif.overrun}, {7'd0, m_ovr});
    endtask

    task automatic wait_col(input logic [3:0] c);
        int k;
        k = 0;
        while (col == c && k < 20) begin cyc(); k++; end
        while (col != c && k < 40) begin cyc(); k++; end
        if (col != c) chk("wait_col_timeout", {4'd0, col}, {4'd0, c});
    endtask

    task automatic press(input logic [3:0] c, input logic [3:0] r, input int ticks);
        wait_col(c);
        filas = r;
        repeat (ticks * SD) cyc();
    endtask

    typedef struct { int ci; int ri; logic [3:0] code; } kv_t;
    kv_t tbl [16];

    initial begin
        int x0;
        tbl = '{'{0,0,4'h1}, '{0,1,4'h2}, '{0,2,4'h3}, '{0,3,4'hA},
                '{1,0,4'h4}, '{1,1,4'h5}, '{1,2,4'h6}, '{1,3,4'hB},
                '{2,0,4'h7}, '{2,1,4'h8}, '{2,2,4'h9}, '{2,3,4'hC},
                '{3,0,4'hE}, '{3,1,4'h0}, '{3,2,4'hF}, '{3,3,4'hD}};
        kif.key_ready = 1'b0;
        kif.ovr_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_col", {4'd0, col}, 8'h08);
        chk("rst_valid", {7'd0, kif.key_valid}, 8'd0);
        chk("rst_code", {4'd0, kif.key_code}, 8'd0);
        chk("rst_down", {7'd0, kif.key_down}, 8'd0);
        chk("rst_ovr", {7'd0, kif.overrun}, 8'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t1_col", {4'd0, col}, {4'd0, 4'b1000 >> k});
            repeat (SD) cyc();
            chk("t1_valid", {7'd0, kif.key_valid}, 8'd0);
        end
        chk("t1_wrap", {4'd0, col}, 8'h08);

        kif.key_ready = 1'b1;
        press(4'b0010, 4'b0100, DS);
        chk("t2_valid", {7'd0, kif.key_valid}, 8'd1);
        chk("t2_code", {4'd0, kif.key_code}, 8'h08);
        chk("t2_down", {7'd0, kif.key_down}, 8'd1);
        chk("t2_col", {4'd0, col}, 8'h02);
        x0 = xfers;
        cyc();
        chk("t2_xfer", 8'(xfers - x0), 8'd1);
        chk("t2_valid_clr", {7'd0, kif.key_valid}, 8'd0);

        repeat (20 * SD) cyc();
        chk("t3_norepeat", 8'(xfers - x0), 8'd1);
        chk("t3_col_held", {4'd0, col}, 8'h02);
        filas = 4'd0;
        repeat (DS * SD) cyc();
        chk("t3_down", {7'd0, kif.key_down}, 8'd0);
        chk("t3_col", {4'd0, col}, 8'h01);

        x0 = xfers;
        press(4'b1000, 4'b1000, 2);
        filas = 4'd0;
        repeat (SD) cyc();
        chk("t4_col", {4'd0, col}, 8'h04);
        chk("t4_noev", 8'(xfers - x0), 8'd0);
        chk("t4_down", {7'd0, kif.key_down}, 8'd0);

        kif.key_ready = 1'b0;
        press(4'b0100, 4'b0100, DS);
        filas = 4'd0;
        repeat (DS * SD) cyc();
        press(4'b0001, 4'b0010, DS);
        chk("t5_code", {4'd0, kif.key_code}, 8'h05);
        chk("t5_valid", {7'd0, kif.key_valid}, 8'd1);
        chk("t5_ovr", {7'd0, kif.overrun}, 8'd1);
        filas = 4'd0;
        repeat (DS * SD) cyc();
        x0 = xfers;
        kif.key_ready = 1'b1;
        cyc();
        chk("t5_xfer", 8'(xfers - x0), 8'd1);
        chk("t5_xcode", {4'd0, last_code}, 8'h05);
        chk("t5_ovr_kept", {7'd0, kif.overrun}, 8'd1);
        kif.ovr_clr = 1'b1;
        cyc();
        kif.ovr_clr = 1'b0;
        chk("t5_ovr_clr", {7'd0, kif.overrun}, 8'd0);

        for (int i = 0; i < 16; i++) begin
            press(4'b1000 >> tbl[i].ci, 4'b1000 >> tbl[i].ri, DS);
            chk("map_valid", {7'd0, kif.key_valid}, 8'd1);
            chk("map_code", {4'd0, kif.key_code}, {4'd0, tbl[i].code});
            filas = 4'd0;
            repeat (DS * SD) cyc();
        end

        x0 = xfers;
        press(4'b0100, 4'b1100, 4);
        chk("t6_ghost_col", {4'd0, col}, 8'h04);
        chk("t6_ghost_down", {7'd0, kif.key_down}, 8'd0);
        chk("t6_ghost_noev", 8'(xfers - x0), 8'd0);
        kif.key_ready = 1'b0;
        filas = 4'd0;
        press(4'b0100, 4'b0100, DS);
        filas = 4'd0;
        repeat (DS * SD) cyc();
        wait_col(4'b0010);
        filas = 4'b0010;
        repeat (SD + 2) cyc();
        chk("t6_pre_valid", {7'd0, kif.key_valid}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_col", {4'd0, col}, 8'h08);
        chk("t6_rst_valid", {7'd0, kif.key_valid}, 8'd0);
        chk("t6_rst_code", {4'd0, kif.key_code}, 8'd0);
        chk("t6_rst_down", {7'd0, kif.key_down}, 8'd0);
        model_reset();
        filas = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * SD) cyc();

        for (int i = 0; i < 70; i++) begin
            int kind, hold;
            kind = $urandom_range(0, 9);
            filas = kind < 4 ? 4'd0 : kind < 8 ? 4'b1000 >> $urandom_range(0, 3) :
                    4'b1100 >> $urandom_range(0, 2);
            hold = $urandom_range(1, 6) * SD + $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                kif.key_ready = $urandom_range(0, 3) != 0;
                kif.ovr_clr = $urandom_range(0, 15) == 0;
                cyc();
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
